// File: rtl/debug_trace_uart.sv
`timescale 1ns/1ps
// debug_trace_uart
// Serialises the computer's debug trace onto one UART TX pin. PC changes and
// data-memory writes are captured into a small FIFO (writes win a tie), each
// record is rendered as an ASCII hex line and shifted out 8N1, LSB first.
//
// Ports
//   clk              in   system clock, all logic on posedge
//   reset            in   asynchronous active-low reset
//   debug_pc         in   current program counter
//   debug_load_m     in   data-memory write strobe, one cycle per write
//   debug_address_m  in   write address, valid with debug_load_m
//   debug_out_m      in   write data, valid with debug_load_m
//   txp              out  UART TX, idle high
//   busy             out  FIFO non-empty or formatter active
//   overflow         out  sticky, set when an event is dropped
module debug_trace_uart #(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] debug_pc,
    input  logic        debug_load_m,
    input  logic [15:0] debug_address_m,
    input  logic [15:0] debug_out_m,
    output logic        txp,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    // ------------------------------------------------------------------
    // Event capture and FIFO
    // ------------------------------------------------------------------
    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_pc_last;
    logic          r_overflow;
    logic [1:0]    r_state;

    logic          w_pc_evt;
    logic          w_push_req;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [32:0]   w_entry;

    assign w_pc_evt   = (debug_pc != r_pc_last);
    assign w_push_req = debug_load_m | w_pc_evt;
    // Full is judged on the count at the start of the cycle; a same-edge pop does not help.
    assign w_full     = (r_count == FIFO_FULL);
    assign w_push     = w_push_req & ~w_full;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_entry    = debug_load_m ? {1'b1, debug_address_m, debug_out_m}
                                     : {1'b0, debug_pc, 16'h0000};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pc_last  <= 16'hFFFF;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end
            // A PC event losing to a write stays pending; a dropped PC event
            // still advances pc_last so one PC is not dropped repeatedly.
            if (!debug_load_m && w_pc_evt) begin
                r_pc_last <= debug_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line formatter
    // ------------------------------------------------------------------
    logic [32:0] r_rec;
    logic [3:0]  r_idx;
    logic [3:0]  r_last_idx;
    logic [7:0]  w_char;
    logic        w_done;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        w_char = 8'h20;
        if (r_rec[32]) begin
            case (r_idx)
                4'd0:    w_char = 8'h57;
                4'd1:    w_char = 8'h20;
                4'd2:    w_char = hex_ascii(r_rec[31:28]);
                4'd3:    w_char = hex_ascii(r_rec[27:24]);
                4'd4:    w_char = hex_ascii(r_rec[23:20]);
                4'd5:    w_char = hex_ascii(r_rec[19:16]);
                4'd6:    w_char = 8'h20;
                4'd7:    w_char = hex_ascii(r_rec[15:12]);
                4'd8:    w_char = hex_ascii(r_rec[11:8]);
                4'd9:    w_char = hex_ascii(r_rec[7:4]);
                4'd10:   w_char = hex_ascii(r_rec[3:0]);
                4'd11:   w_char = 8'h0D;
                4'd12:   w_char = 8'h0A;
                default: w_char = 8'h20;
            endcase
        end else begin
            case (r_idx)
                4'd0:    w_char = 8'h50;
                4'd1:    w_char = 8'h20;
                4'd2:    w_char = hex_ascii(r_rec[31:28]);
                4'd3:    w_char = hex_ascii(r_rec[27:24]);
                4'd4:    w_char = hex_ascii(r_rec[23:20]);
                4'd5:    w_char = hex_ascii(r_rec[19:16]);
                4'd6:    w_char = 8'h0D;
                4'd7:    w_char = 8'h0A;
                default: w_char = 8'h20;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rec      <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_rec   <= r_mem[r_rptr];
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_idx      <= 4'd0;
                    r_last_idx <= r_rec[32] ? 4'd12 : 4'd7;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done) begin
                        if (r_idx == r_last_idx) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_SEND;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // 8N1 shifter; bit index 0 = start, 1..8 = data, 9 = stop
    // ------------------------------------------------------------------
    logic          r_tx;
    logic          r_active;
    logic [7:0]    r_sh;
    logic [3:0]    r_bit;
    logic [CW-1:0] r_cnt;
    logic          w_start;

    assign w_start = (r_state == S_SEND);
    assign w_done  = r_active && (r_bit == 4'd9) && (r_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_sh     <= '0;
            r_bit    <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_tx     <= 1'b0;
            r_active <= 1'b1;
            r_sh     <= w_char;
            r_bit    <= 4'd0;
            r_cnt    <= '0;
        end else if (r_active) begin
            if (r_cnt == DIV_LAST) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    // Leaving bit k presents data bit k, or the stop bit after bit 8.
                    r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_sh[r_bit[2:0]];
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign txp      = r_tx;
    assign busy     = (r_count != '0) || (r_state != S_IDLE);
    assign overflow = r_overflow;

endmodule
